// File: rtl/latch_mem_ctrl.sv
// latch_mem_ctrl: round-robin arbiter and access sequencer for the 8-row
// NAND-latch bitcell array behind a 3-to-8 address decoder.
// Each access is SETUP -> STROBE (STROBE_CYC cycles) -> DONE, so the
// decoder address is stable on both edges of the select strobe.
module latch_mem_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              dec_select,
  output logic [ADDR_W-1:0] dec_adr,
  output logic              bit_we,
  output logic [DATA_W-1:0] bit_din,
  input  logic [DATA_W-1:0] bit_dout
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Latched command; gnt records which requester owns the access.
  typedef struct packed {
    logic              gnt;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t           r_state, w_state_nxt;
  cmd_t             r_cmd, w_cmd_req;
  logic             r_last_gnt;
  logic [CNT_W-1:0] r_cnt;

  logic w_any_req;
  logic w_gnt;
  logic w_strobe_last;

  // Registered outputs and their next values.
  logic              r_ack0, r_ack1, r_busy, r_sel, r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_din, r_rdata;
  logic              w_ack0_d, w_ack1_d, w_busy_d, w_sel_d, w_we_d;
  logic [ADDR_W-1:0] w_adr_d;
  logic [DATA_W-1:0] w_din_d, w_rdata_d;

  // Arbitration: a tie goes to the requester that was not served last.
  always_comb begin
    w_any_req = req0 | req1;
    w_gnt     = (req0 & req1) ? ~r_last_gnt : req1;
    if (w_gnt) begin
      w_cmd_req.gnt   = 1'b1;
      w_cmd_req.we    = we1;
      w_cmd_req.addr  = addr1;
      w_cmd_req.wdata = wdata1;
    end else begin
      w_cmd_req.gnt   = 1'b0;
      w_cmd_req.we    = we0;
      w_cmd_req.addr  = addr0;
      w_cmd_req.wdata = wdata0;
    end
  end

  assign w_strobe_last = (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so the other side gets a slot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req)     w_state_nxt = S_SETUP;
      S_SETUP:                     w_state_nxt = S_STROBE;
      S_STROBE: if (w_strobe_last) w_state_nxt = S_DONE;
      S_DONE:                      w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: values the outputs take in the coming state, so every
  // output can be a flop without adding a cycle of latency.
  always_comb begin
    w_sel_d   = 1'b0;
    w_we_d    = 1'b0;
    w_adr_d   = r_adr;
    w_din_d   = r_din;
    w_ack0_d  = 1'b0;
    w_ack1_d  = 1'b0;
    w_rdata_d = r_rdata;
    w_busy_d  = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_adr_d = w_cmd_req.addr;
          w_din_d = w_cmd_req.wdata;
          w_we_d  = w_cmd_req.we;
        end
      end
      S_SETUP: begin
        w_sel_d = 1'b1;
        w_we_d  = r_cmd.we;
      end
      S_STROBE: begin
        if (w_strobe_last) begin
          w_ack0_d = ~r_cmd.gnt;
          w_ack1_d = r_cmd.gnt;
          if (!r_cmd.we) w_rdata_d = bit_dout;
        end else begin
          w_sel_d = 1'b1;
          w_we_d  = r_cmd.we;
        end
      end
      default: ;
    endcase
  end

  // Output registers; async reset drops select and write enable immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_din   <= '0;
      r_rdata <= '0;
    end else begin
      r_ack0  <= w_ack0_d;
      r_ack1  <= w_ack1_d;
      r_busy  <= w_busy_d;
      r_sel   <= w_sel_d;
      r_we    <= w_we_d;
      r_adr   <= w_adr_d;
      r_din   <= w_din_d;
      r_rdata <= w_rdata_d;
    end
  end

  // Command latch: captured at grant, later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cmd <= '0;
    else if (r_state == S_IDLE && w_any_req) r_cmd <= w_cmd_req;
  end

  // Strobe length down-counter, loaded in SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_cnt <= '0;
    else if (r_state == S_SETUP)                  r_cnt <= CNT_LOAD;
    else if (r_state == S_STROBE && !w_strobe_last) r_cnt <= r_cnt - CNT_W'(1);
  end

  // Round-robin pointer, updated as the access enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_last_gnt <= 1'b1;
    else if (r_state == S_STROBE && w_strobe_last) r_last_gnt <= r_cmd.gnt;
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign busy       = r_busy;
  assign dec_select = r_sel;
  assign bit_we     = r_we;
  assign dec_adr    = r_adr;
  assign bit_din    = r_din;
  assign rdata      = r_rdata;

endmodule

// File: tb/tb_latch_mem_ctrl.sv
// Directed bench for latch_mem_ctrl: default build with a bitcell array
// model, plus a STROBE_CYC=3 build for the long-strobe case.
module tb_latch_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Default build (STROBE_CYC = 1)
  logic       req0, we0, req1, we1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, dec_select, bit_we;
  logic [2:0] dec_adr;
  logic [7:0] rdata, bit_din, bit_dout;

  // STROBE_CYC = 3 build
  logic       b_req0, b_we0, b_req1, b_we1;
  logic [2:0] b_addr0, b_addr1;
  logic [7:0] b_wdata0, b_wdata1;
  logic       b_ack0, b_ack1, b_busy, b_dec_select, b_bit_we;
  logic [2:0] b_dec_adr;
  logic [7:0] b_rdata, b_bit_din, b_bit_dout;

  latch_mem_ctrl #(.DATA_W(8), .ADDR_W(3), .STROBE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .dec_select(dec_select), .dec_adr(dec_adr), .bit_we(bit_we),
    .bit_din(bit_din), .bit_dout(bit_dout)
  );

  latch_mem_ctrl #(.DATA_W(8), .ADDR_W(3), .STROBE_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
    .dec_select(b_dec_select), .dec_adr(b_dec_adr), .bit_we(b_bit_we),
    .bit_din(b_bit_din), .bit_dout(b_bit_dout)
  );

  // Bitcell array model: row written while selected with write enable.
  logic [7:0] mem [8];
  always @(posedge clk) if (dec_select && bit_we) mem[dec_adr] <= bit_din;
  assign bit_dout   = mem[dec_adr];
  assign b_bit_dout = 8'hC3;

  // Protocol monitor on the default build.
  int         viol = 0, sel_run = 0, last_run = 0;
  logic       prev_sel = 1'b0;
  logic [2:0] prev_adr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sel_run  <= 0;
      prev_sel <= 1'b0;
    end else begin
      viol <= viol + int'(dec_select && prev_sel && (dec_adr !== prev_adr))
                   + int'(ack0 && ack1)
                   + int'((ack0 || ack1) && dec_select);
      if (dec_select) sel_run <= sel_run + 1;
      else if (prev_sel) begin
        last_run <= sel_run;
        sel_run  <= 0;
      end
      prev_sel <= dec_select;
      prev_adr <= dec_adr;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full access by requester r, bounded wait for its ack.
  task automatic access(input int r, input logic we, input logic [2:0] a,
                        input logic [7:0] d, output logic [7:0] rd);
    logic got;
    if (r == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick;
      if ((r == 0) ? ack0 : ack1) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    chk("other_ack_low", (r == 0) ? ack1 : ack0, 0);
    rd = rdata;
    if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    tick;
  endtask

  logic [7:0] rd;
  logic       got;

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
    b_req1 = 0; b_we1 = 0; b_addr1 = 0; b_wdata1 = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset state
    #3;
    chk("reset_outs", {ack0, ack1, busy, dec_select, bit_we, dec_adr, bit_din, rdata}, 0);
    #9 rst_n = 1'b1;
    tick;

    // Write A5 to row 5 from requester 0, cycle by cycle
    req0 = 1; we0 = 1; addr0 = 3'b101; wdata0 = 8'hA5;
    tick;  // cycle 1: SETUP
    chk("wr_setup_adr", dec_adr, 3'b101);
    chk("wr_setup_we", bit_we, 1);
    chk("wr_setup_sel", dec_select, 0);
    chk("wr_setup_din", bit_din, 8'hA5);
    chk("wr_setup_busy", busy, 1);
    tick;  // cycle 2: STROBE
    chk("wr_strobe_sel", dec_select, 1);
    chk("wr_strobe_ack", ack0, 0);
    chk("wr_strobe_busy", busy, 1);
    tick;  // cycle 3: DONE
    chk("wr_done_ack0", ack0, 1);
    chk("wr_done_ack1", ack1, 0);
    chk("wr_done_sel", dec_select, 0);
    chk("wr_done_we", bit_we, 0);
    chk("wr_done_adr", dec_adr, 3'b101);
    chk("wr_done_busy", busy, 1);
    req0 = 0;
    tick;  // cycle 4: IDLE
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_ack", ack0, 0);
    chk("wr_mem", mem[5], 8'hA5);

    // Read row 5 via requester 1
    req1 = 1; we1 = 0; addr1 = 3'b101; wdata1 = 8'hFF;
    tick;
    chk("rd_setup_we", bit_we, 0);
    chk("rd_setup_adr", dec_adr, 3'b101);
    tick;
    chk("rd_strobe_sel", dec_select, 1);
    tick;
    chk("rd_ack1", ack1, 1);
    chk("rd_ack0", ack0, 0);
    chk("rd_rdata", rdata, 8'hA5);
    req1 = 0;
    tick;
    chk("rd_sel_len", last_run, 1);

    // A write leaves rdata at its previous value
    access(0, 1'b1, 3'd0, 8'h11, rd);
    chk("wr_keeps_rdata", rd, 8'hA5);

    // Simultaneous requests right after reset: strict alternation 0,1,0,1
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 8'h01;
    req1 = 1; we1 = 1; addr1 = 3'd2; wdata1 = 8'h02;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int j = 0; j < 10 && !got; j++) begin
        tick;
        if (ack0 || ack1) got = 1'b1;
      end
      chk("rr_ack", got, 1);
      chk("rr_order", ack1, k % 2);
      chk("rr_onehot", ack0 ^ ack1, 1);
      if (k == 3) begin req0 = 0; req1 = 0; end
      tick;
      chk("rr_idle_gap", busy, 0);
    end

    // Address sweep: write every row, then read each back
    for (int i = 0; i < 8; i++)
      access(0, 1'b1, 3'(i), 8'h3C ^ 8'(i * 17), rd);
    for (int i = 0; i < 8; i++) begin
      access(1, 1'b0, 3'(i), 8'h00, rd);
      chk("sweep_rd", rd, 8'h3C ^ 8'(i * 17));
    end

    // Reset during STROBE aborts the access at once
    req0 = 1; we0 = 1; addr0 = 3'd2; wdata0 = 8'h77;
    tick;
    tick;
    chk("abort_pre_sel", dec_select, 1);
    req0 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", {dec_select, bit_we, busy, ack0, ack1}, 0);
    rst_n = 1'b1;
    tick;
    chk("abort_idle", busy, 0);
    chk("abort_nowrite", mem[2], 8'h1E);
    access(0, 1'b1, 3'd2, 8'h77, rd);
    access(1, 1'b0, 3'd2, 8'h00, rd);
    chk("abort_retry_rd", rd, 8'h77);

    // STROBE_CYC=3 build, req0 dropped during SETUP
    b_req0 = 1; b_we0 = 1; b_addr0 = 3'd6; b_wdata0 = 8'h5A;
    tick;  // cycle 1
    chk("b_setup_busy", b_busy, 1);
    chk("b_setup_sel", b_dec_select, 0);
    chk("b_setup_adr", b_dec_adr, 3'd6);
    chk("b_setup_we", b_bit_we, 1);
    b_req0 = 0;
    for (int c = 2; c <= 4; c++) begin
      tick;
      chk("b_strobe_sel", b_dec_select, 1);
      chk("b_strobe_ack", b_ack0, 0);
      chk("b_strobe_din", b_bit_din, 8'h5A);
    end
    tick;  // cycle 5
    chk("b_done_ack0", b_ack0, 1);
    chk("b_done_sel", b_dec_select, 0);
    chk("b_done_we", b_bit_we, 0);
    chk("b_done_adr", b_dec_adr, 3'd6);
    chk("b_done_rdata", b_rdata, 8'h00);
    tick;
    chk("b_idle_busy", b_busy, 0);
    chk("b_idle_ack", b_ack0, 0);

    chk("monitor_viol", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
